regfile_wb_ctrl: RTL and testbench

//  Write-side driver for the 32x32 register file; sole source of its we/waddr/wdata.

---
 rtl/regfile_wb_ctrl_pkg.sv | 29 ++
 rtl/regfile_wb_ctrl_wb_fifo.sv | 143 ++++++++++++++
 rtl/regfile_wb_ctrl.sv | 176 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
//  Shared constants and types for the register-file write-back controller.
//  Contents:
//    VALID / INVALID  : live-bit encodings for secondary FIFO entries
//    WB_DEPTH         : default secondary FIFO depth
//    WB_PTR_W         : pointer width for the default depth (log2(depth)+1)
//    wr_sel_e         : write-port source select
//    reg_onehot()     : one-hot decode of a register index into a 32-bit mask
// ---------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

    localparam logic VALID    = 1'b1;
    localparam logic INVALID  = 1'b0;
    localparam int   WB_DEPTH = 4;
    localparam int   WB_PTR_W = 3;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PRI  = 2'd1,
        SEL_SEC  = 2'd2
    } wr_sel_e;

    // Indices above 31 decode to an empty mask.
    function automatic logic [31:0] reg_onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//  Secondary-result buffer for the write-back controller. Holds address, data
//  and a live bit per slot. A slot is live only while it is occupied, targets a
//  non-zero register and has not been squashed by a younger primary write.
//  Ports:
//    clk, rst            clock, asynchronous active-low reset
//    push/push_addr/data push request (ignored while full)
//    pop                 pop request (ignored while empty)
//    sq_en/sq_addr       kill every live entry targeting sq_addr (incl. same-cycle push)
//    full, empty         occupancy flags from registered pointers
//    head_live/addr/data head-of-queue view
//    rd_idx              storage index of the head (oldest) slot
//    live_vec            per-slot live bits
//    ent_addr/ent_data   flattened per-slot address/data
//    pend_mask           OR of one-hot decodes of live entry addresses
// ---------------------------------------------------------------------------
module wb_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AW-1:0]         push_addr,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    input  logic                  sq_en,
    input  logic [AW-1:0]         sq_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  head_live,
    output logic [AW-1:0]         head_addr,
    output logic [DW-1:0]         head_data,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DEPTH-1:0]      live_vec,
    output logic [DEPTH*AW-1:0]   ent_addr,
    output logic [DEPTH*DW-1:0]   ent_data,
    output logic [31:0]           pend_mask
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [AW-1:0]    addr_r [DEPTH];
    logic [DW-1:0]    data_r [DEPTH];
    logic [DEPTH-1:0] live_r;
    logic [DEPTH-1:0] live_nxt_s;
    logic [IW-1:0]    wr_idx_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Equal low bits with differing MSBs means the writer has lapped the reader.
    assign wr_idx_s  = wptr_r[IW-1:0];
    assign rd_idx    = rptr_r[IW-1:0];
    assign full      = (wptr_r[PW-1] != rptr_r[PW-1]) && (wr_idx_s == rd_idx);
    assign empty     = (wptr_r == rptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_live = live_r[rd_idx];
    assign head_addr = addr_r[rd_idx];
    assign head_data = data_r[rd_idx];
    assign live_vec  = live_r;

    // Flatten slot storage for the lookup logic in the parent.
    always_comb begin
        ent_addr = '0;
        ent_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i*AW +: AW] = addr_r[i];
            ent_data[i*DW +: DW] = data_r[i];
        end
    end

    // Next live bits: a new entry is born dead if it targets r0 or the same-cycle
    // primary write; popped slots are freed; a primary write kills matching entries.
    always_comb begin
        live_nxt_s = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push_s && (wr_idx_s == IW'(i))) begin
                live_nxt_s[i] = (push_addr != '0) && !(sq_en && (push_addr == sq_addr));
            end else if (do_pop_s && (rd_idx == IW'(i))) begin
                live_nxt_s[i] = INVALID;
            end else if (sq_en && (addr_r[i] == sq_addr)) begin
                live_nxt_s[i] = INVALID;
            end else begin
                live_nxt_s[i] = live_r[i];
            end
        end
    end

    // Pointers and live bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
            live_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            live_r <= live_nxt_s;
        end
    end

    // Slot address/data storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else if (do_push_s) begin
            addr_r[wr_idx_s] <= push_addr;
            data_r[wr_idx_s] <= push_data;
        end
    end

    // Pending-write mask; r0 entries are never live so bit 0 stays clear.
    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_r[i]) begin
                pend_mask = pend_mask | reg_onehot(32'(addr_r[i]));
            end else begin
                pend_mask = pend_mask;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//  Sole driver of the 32x32 register file write port. The single-cycle
//  pipeline write-back (primary) always wins; long-latency results
//  (secondary) queue in wb_fifo and issue when the port is free. A pending
//  mask of live queued destinations feeds ID-stage stall logic.
//  Build option: define FWD_EN to enable the combinational forwarding lookup
//  (q_*); without it q_hit_* and q_data_* are tied to zero.
//  Ports:
//    clk, rst                   clock, asynchronous active-low reset
//    p_we/p_waddr/p_wdata       primary write request (never stalled)
//    s_valid/s_ready            secondary handshake (s_ready = !full)
//    s_waddr/s_wdata            secondary destination and data
//    we/waddr/wdata             registered register-file write port
//    pend_mask                  live queued destinations, one bit per register
//    q_addr_a/b, q_hit_a/b, q_data_a/b   forwarding lookup
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_we,
    input  logic [AW-1:0] p_waddr,
    input  logic [DW-1:0] p_wdata,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [AW-1:0] s_waddr,
    input  logic [DW-1:0] s_wdata,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [31:0]   pend_mask,
    input  logic [AW-1:0] q_addr_a,
    input  logic [AW-1:0] q_addr_b,
    output logic          q_hit_a,
    output logic          q_hit_b,
    output logic [DW-1:0] q_data_a,
    output logic [DW-1:0] q_data_b
);

    localparam int IW = $clog2(DEPTH);

    logic                p_valid_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic                head_live_s;
    logic [AW-1:0]       head_addr_s;
    logic [DW-1:0]       head_data_s;
    logic [IW-1:0]       rd_idx_s;
    logic [DEPTH-1:0]    live_vec_s;
    logic [DEPTH*AW-1:0] ent_addr_s;
    logic [DEPTH*DW-1:0] ent_data_s;
    wr_sel_e             sel_s;
    logic                we_r;
    logic [AW-1:0]       waddr_r;
    logic [DW-1:0]       wdata_r;

    assign p_valid_s = p_we && (p_waddr != '0);
    assign s_ready   = !full_s;
    assign we        = we_r;
    assign waddr     = waddr_r;
    assign wdata     = wdata_r;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_addr (s_waddr),
        .push_data (s_wdata),
        .pop       (pop_s),
        .sq_en     (p_valid_s),
        .sq_addr   (p_waddr),
        .full      (full_s),
        .empty     (empty_s),
        .head_live (head_live_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .rd_idx    (rd_idx_s),
        .live_vec  (live_vec_s),
        .ent_addr  (ent_addr_s),
        .ent_data  (ent_data_s),
        .pend_mask (pend_mask)
    );

    // Dead heads drain without the port, so they may pop under a primary write.
    always_comb begin
        pop_s = !empty_s && (!head_live_s || !p_valid_s);
        if (p_valid_s) begin
            sel_s = SEL_PRI;
        end else if (pop_s && head_live_s) begin
            sel_s = SEL_SEC;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Write-port output register; address and data hold on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else begin
            case (sel_s)
                SEL_PRI: begin
                    we_r    <= 1'b1;
                    waddr_r <= p_waddr;
                    wdata_r <= p_wdata;
                end
                SEL_SEC: begin
                    we_r    <= 1'b1;
                    waddr_r <= head_addr_s;
                    wdata_r <= head_data_s;
                end
                default: begin
                    we_r    <= 1'b0;
                    waddr_r <= waddr_r;
                    wdata_r <= wdata_r;
                end
            endcase
        end
    end

`ifdef FWD_EN
    // Scan the output register first, then the FIFO oldest to youngest so the
    // youngest live match overrides everything before it.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] q);
        logic          hit;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if ((q != '0) && we_r && (waddr_r == q)) begin
            hit  = 1'b1;
            data = wdata_r;
        end else begin
            hit  = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_idx_s + IW'(k);
            if ((q != '0) && live_vec_s[idx] && (ent_addr_s[idx*AW +: AW] == q)) begin
                hit  = 1'b1;
                data = ent_data_s[idx*DW +: DW];
            end else begin
                hit  = hit;
            end
        end
        return {hit, data};
    endfunction

    // Combinational forwarding lookup for both read ports.
    always_comb begin
        {q_hit_a, q_data_a} = fwd_lookup(q_addr_a);
        {q_hit_b, q_data_b} = fwd_lookup(q_addr_b);
    end
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^{q_addr_a, q_addr_b, rd_idx_s, live_vec_s, ent_addr_s, ent_data_s};
    assign q_hit_a      = 1'b0;
    assign q_hit_b      = 1'b0;
    assign q_data_a     = '0;
    assign q_data_b     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
//  Directed bench for regfile_wb_ctrl. Inputs change 1 time unit after a
//  rising edge and outputs are sampled 1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend_mask;
    logic [4:0]  q_addr_a;
    logic [4:0]  q_addr_b;
    logic        q_hit_a;
    logic        q_hit_b;
    logic [31:0] q_data_a;
    logic [31:0] q_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .we(we), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .q_hit_a(q_hit_a), .q_hit_b(q_hit_b),
        .q_data_a(q_data_a), .q_data_b(q_data_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_we = 1'b0; p_waddr = 5'd0; p_wdata = 32'd0;
        s_valid = 1'b0; s_waddr = 5'd0; s_wdata = 32'd0;
        q_addr_a = 5'd0; q_addr_b = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL reset_port: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd0, 32'd0});
        end
        n_checks++;
        if (pend_mask !== 32'd0) begin
            n_fail++; $display("FAIL reset_pend: got %h want %h", pend_mask, 32'd0);
        end
        n_checks++;
        if ({s_ready, q_hit_a, q_hit_b} !== 3'b100) begin
            n_fail++; $display("FAIL reset_ready_hit: got %b want %b", {s_ready, q_hit_a, q_hit_b}, 3'b100);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_we: got %b want %b", we, 1'b0);
        end
    endtask

    task automatic test_primary();
        p_we = 1'b1; p_waddr = 5'd5; p_wdata = 32'hA5A5_0001;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hA5A5_0001}) begin
            n_fail++; $display("FAIL prim_issue: got %h want %h", {we, waddr, wdata}, {1'b1, 5'd5, 32'hA5A5_0001});
        end
        p_waddr = 5'd0; p_wdata = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd5, 32'hA5A5_0001}) begin
            n_fail++; $display("FAIL prim_r0: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd5, 32'hA5A5_0001});
        end
        p_we = 1'b0; p_waddr = 5'd6;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd5, 32'hA5A5_0001}) begin
            n_fail++; $display("FAIL prim_noreq: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd5, 32'hA5A5_0001});
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        // Primary to r20 keeps the port busy so the queue can fill.
        p_we = 1'b1; p_waddr = 5'd20; p_wdata = 32'h0000_00F0;
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_waddr = 5'(i); s_wdata = 32'h100 + 32'(i);
            n_checks++;
            if (s_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", i, s_ready, 1'b1);
            end
            tick();
        end
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got %b want %b", s_ready, 1'b0);
        end
        n_checks++;
        if (pend_mask !== 32'h0000_001E) begin
            n_fail++; $display("FAIL fill_pend: got %h want %h", pend_mask, 32'h0000_001E);
        end
        // Full and popping this cycle: the offered r10 must not be taken yet.
        s_waddr = 5'd10; s_wdata = 32'h10A; p_we = 1'b0;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd1, 32'h101}) begin
            n_fail++; $display("FAIL fill_issue_r1: got %h want %h", {we, waddr, wdata}, {1'b1, 5'd1, 32'h101});
        end
        n_checks++;
        if ({s_ready, pend_mask} !== {1'b1, 32'h0000_001C}) begin
            n_fail++; $display("FAIL fill_nopush_full: got %h want %h", {s_ready, pend_mask}, {1'b1, 32'h0000_001C});
        end
        tick();
        n_checks++;
        if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd2, 32'h102, 32'h0000_0418}) begin
            n_fail++; $display("FAIL fill_issue_r2: got %h want %h", {we, waddr, wdata, pend_mask}, {1'b1, 5'd2, 32'h102, 32'h0000_0418});
        end
        s_valid = 1'b0;
        for (int i = 3; i <= 4; i++) begin
            tick();
            n_checks++;
            if ({we, waddr, wdata} !== {1'b1, 5'(i), 32'h100 + 32'(i)}) begin
                n_fail++; $display("FAIL fill_issue_r%0d: got %h want %h", i, {we, waddr, wdata}, {1'b1, 5'(i), 32'h100 + 32'(i)});
            end
        end
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd10, 32'h10A}) begin
            n_fail++; $display("FAIL fill_issue_r10: got %h want %h", {we, waddr, wdata}, {1'b1, 5'd10, 32'h10A});
        end
        tick();
        n_checks++;
        if ({we, pend_mask} !== {1'b0, 32'd0}) begin
            n_fail++; $display("FAIL fill_drained: got %h want %h", {we, pend_mask}, {1'b0, 32'd0});
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        p_we = 1'b1; p_waddr = 5'd7; p_wdata = 32'h77;
        s_valid = 1'b1; s_waddr = 5'd3; s_wdata = 32'h33;
        tick();
        s_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd7, 32'h77 + 32'(j), 32'h8}) begin
                n_fail++; $display("FAIL cont_hold_%0d: got %h want %h", j, {we, waddr, wdata, pend_mask}, {1'b1, 5'd7, 32'h77 + 32'(j), 32'h8});
            end
            p_wdata = 32'h78 + 32'(j);
            tick();
        end
        p_we = 1'b0;
        tick();
        n_checks++;
        if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd3, 32'h33, 32'd0}) begin
            n_fail++; $display("FAIL cont_issue: got %h want %h", {we, waddr, wdata, pend_mask}, {1'b1, 5'd3, 32'h33, 32'd0});
        end
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd3, 32'h33}) begin
            n_fail++; $display("FAIL cont_idle: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd3, 32'h33});
        end
        idle_inputs();
    endtask

    task automatic test_squash();
        p_we = 1'b1; p_waddr = 5'd7; p_wdata = 32'h70;
        s_valid = 1'b1; s_waddr = 5'd9; s_wdata = 32'h11;
        tick();
        n_checks++;
        if (pend_mask !== 32'h0000_0200) begin
            n_fail++; $display("FAIL sq_pend_set: got %h want %h", pend_mask, 32'h0000_0200);
        end
        s_valid = 1'b0; p_waddr = 5'd9; p_wdata = 32'h22;
        tick();
        n_checks++;
        if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd9, 32'h22, 32'd0}) begin
            n_fail++; $display("FAIL sq_primary: got %h want %h", {we, waddr, wdata, pend_mask}, {1'b1, 5'd9, 32'h22, 32'd0});
        end
        p_we = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick();
            n_checks++;
            if ({we, waddr, wdata} !== {1'b0, 5'd9, 32'h22}) begin
                n_fail++; $display("FAIL sq_dead_pop_%0d: got %h want %h", j, {we, waddr, wdata}, {1'b0, 5'd9, 32'h22});
            end
        end
        // Same-cycle push and primary to r12: the queued copy dies on arrival.
        p_we = 1'b1; p_waddr = 5'd12; p_wdata = 32'hAA;
        s_valid = 1'b1; s_waddr = 5'd12; s_wdata = 32'hBB;
        tick();
        n_checks++;
        if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd12, 32'hAA, 32'd0}) begin
            n_fail++; $display("FAIL sq_same_cycle: got %h want %h", {we, waddr, wdata, pend_mask}, {1'b1, 5'd12, 32'hAA, 32'd0});
        end
        idle_inputs();
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd12, 32'hAA}) begin
            n_fail++; $display("FAIL sq_same_nowrite: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd12, 32'hAA});
        end
        // Secondary r0 is accepted then dropped.
        s_valid = 1'b1; s_waddr = 5'd0; s_wdata = 32'hCC;
        tick();
        n_checks++;
        if ({s_ready, pend_mask} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL sq_r0_accept: got %h want %h", {s_ready, pend_mask}, {1'b1, 32'd0});
        end
        s_valid = 1'b0;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b0, 5'd12, 32'hAA}) begin
            n_fail++; $display("FAIL sq_r0_drop: got %h want %h", {we, waddr, wdata}, {1'b0, 5'd12, 32'hAA});
        end
        // Dead r0 head must drain under an active primary so r2 issues immediately after.
        p_we = 1'b1; p_waddr = 5'd7; p_wdata = 32'h71;
        s_valid = 1'b1; s_waddr = 5'd0; s_wdata = 32'h0;
        tick();
        s_waddr = 5'd2; s_wdata = 32'h222;
        tick();
        s_valid = 1'b0;
        tick();
        p_we = 1'b0;
        tick();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd2, 32'h222}) begin
            n_fail++; $display("FAIL sq_dead_under_pri: got %h want %h", {we, waddr, wdata}, {1'b1, 5'd2, 32'h222});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        p_we = 1'b1; p_waddr = 5'd7; p_wdata = 32'h7;
        s_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_waddr = 5'(i); s_wdata = 32'h200 + 32'(i);
            tick();
        end
        n_checks++;
        if (pend_mask !== 32'h0000_000E) begin
            n_fail++; $display("FAIL rstmid_queued: got %h want %h", pend_mask, 32'h0000_000E);
        end
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({we, waddr, wdata, pend_mask, s_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL rstmid_async: got %h want %h", {we, waddr, wdata, pend_mask, s_ready}, {1'b0, 5'd0, 32'd0, 32'd0, 1'b1});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++;
            if ({we, waddr, wdata, pend_mask} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
                n_fail++; $display("FAIL rstmid_nowrite_%0d: got %h want %h", j, {we, waddr, wdata, pend_mask}, {1'b0, 5'd0, 32'd0, 32'd0});
            end
        end
    endtask

    task automatic test_fwd();
        // Queue r6=0x44 then r6=0x55 behind a busy port, then let 0x44 issue.
        p_we = 1'b1; p_waddr = 5'd20; p_wdata = 32'h20;
        s_valid = 1'b1; s_waddr = 5'd6; s_wdata = 32'h44;
        tick();
        s_wdata = 32'h55;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd6, 32'h44, 32'h40}) begin
            n_fail++; $display("FAIL fwd_setup: got %h want %h", {we, waddr, wdata, pend_mask}, {1'b1, 5'd6, 32'h44, 32'h40});
        end
        q_addr_a = 5'd6; q_addr_b = 5'd20;
        #1;
`ifdef FWD_EN
        n_checks++;
        if ({q_hit_a, q_data_a} !== {1'b1, 32'h55}) begin
            n_fail++; $display("FAIL fwd_youngest: got %h want %h", {q_hit_a, q_data_a}, {1'b1, 32'h55});
        end
        n_checks++;
        if ({q_hit_b, q_data_b} !== {1'b0, 32'd0}) begin
            n_fail++; $display("FAIL fwd_miss_b: got %h want %h", {q_hit_b, q_data_b}, {1'b0, 32'd0});
        end
        q_addr_a = 5'd0;
        #1;
        n_checks++;
        if (q_hit_a !== 1'b0) begin
            n_fail++; $display("FAIL fwd_r0: got %b want %b", q_hit_a, 1'b0);
        end
        q_addr_a = 5'd6; q_addr_b = 5'd6;
        tick();
        n_checks++;
        if ({q_hit_a, q_data_a, q_hit_b, q_data_b} !== {1'b1, 32'h55, 1'b1, 32'h55}) begin
            n_fail++; $display("FAIL fwd_outreg: got %h want %h", {q_hit_a, q_data_a, q_hit_b, q_data_b}, {1'b1, 32'h55, 1'b1, 32'h55});
        end
        tick();
        n_checks++;
        if (q_hit_a !== 1'b0) begin
            n_fail++; $display("FAIL fwd_idle: got %b want %b", q_hit_a, 1'b0);
        end
`else
        n_checks++;
        if ({q_hit_a, q_data_a, q_hit_b, q_data_b} !== {1'b0, 32'd0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL fwd_off: got %h want %h", {q_hit_a, q_data_a, q_hit_b, q_data_b}, {1'b0, 32'd0, 1'b0, 32'd0});
        end
        tick();
        n_checks++;
        if ({we, waddr, wdata, q_hit_a, q_data_a} !== {1'b1, 5'd6, 32'h55, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL fwd_off_issue: got %h want %h", {we, waddr, wdata, q_hit_a, q_data_a}, {1'b1, 5'd6, 32'h55, 1'b0, 32'd0});
        end
        tick();
`endif
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_primary();
        test_fill();
        test_contention();
        test_squash();
        test_reset_mid();
        test_fwd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
